// File: rtl/led_pwm.sv
// RGB LED PWM controller with register interface, glitch-free duty update
// at frame boundaries, and an optional blink mode that gates the outputs
// on and off in units of whole PWM frames.
module led_pwm #(
    parameter int PRESCALE = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b
);

    localparam logic [7:0]  LP_ADDR_DUTY   = 8'h00;
    localparam logic [7:0]  LP_ADDR_CTRL   = 8'h01;
    localparam logic [7:0]  LP_ADDR_PERIOD = 8'h02;
    localparam logic [7:0]  LP_ADDR_STATUS = 8'h03;
    localparam logic [15:0] LP_PRESC_MAX   = 16'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_SOLID,
        ST_BLINK_ON,
        ST_BLINK_OFF
    } state_t;

    // Register file
    logic [23:0] r_duty;
    logic [1:0]  r_ctrl;
    logic [15:0] r_period;
    logic [31:0] r_read_data;
    logic        r_ready;

    // Timing state
    logic [15:0] r_presc;
    logic [7:0]  r_pwm_ctr;
    logic [15:0] r_frame_ctr;
    state_t      r_state;

    // Combinational helpers
    logic        w_wr_duty;
    logic        w_wr_ctrl;
    logic        w_wr_period;
    logic [1:0]  w_ctrl_next;
    logic        w_en_next;
    logic        w_en_rise;
    logic        w_tick;
    logic        w_frame_end;
    logic        w_load_active;
    logic        w_phase_on;
    logic [15:0] w_period_max;
    logic [31:0] w_rd_mux;
    state_t      w_state_next;
    logic [15:0] w_frame_next;
    logic        w_unused;

    assign w_wr_duty   = cs && we && (address == LP_ADDR_DUTY);
    assign w_wr_ctrl   = cs && we && (address == LP_ADDR_CTRL);
    assign w_wr_period = cs && we && (address == LP_ADDR_PERIOD);

    // Control value that will be in effect after this edge; lets the outputs
    // and counters drop on the same edge that clears enable.
    assign w_ctrl_next = w_wr_ctrl ? write_data[1:0] : r_ctrl;
    assign w_en_next   = w_ctrl_next[0];
    assign w_en_rise   = w_wr_ctrl && write_data[0] && !r_ctrl[0];

    assign w_tick        = r_ctrl[0] && (r_presc == LP_PRESC_MAX);
    assign w_frame_end   = w_tick && (r_pwm_ctr == 8'hFF);
    assign w_load_active = w_frame_end || w_en_rise;
    assign w_phase_on    = (r_state != ST_BLINK_OFF);
    assign w_period_max  = (r_period == 16'd0) ? 16'd0 : (r_period - 16'd1);

    // Top byte of the write payload is never stored
    assign w_unused = ^write_data[31:24];

    // Register writes and registered read port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_duty      <= '0;
            r_ctrl      <= '0;
            r_period    <= 16'd64;
            r_read_data <= '0;
            r_ready     <= 1'b0;
        end else begin
            if (w_wr_duty)   r_duty   <= write_data[23:0];
            if (w_wr_ctrl)   r_ctrl   <= write_data[1:0];
            if (w_wr_period) r_period <= write_data[15:0];
            r_ready     <= cs;
            r_read_data <= (cs && !we) ? w_rd_mux : '0;
        end
    end

    // Read multiplexer; unmapped addresses and unused bits return zero
    always_comb begin
        w_rd_mux = '0;
        case (address)
            LP_ADDR_DUTY:   w_rd_mux = {8'h00, r_duty};
            LP_ADDR_CTRL:   w_rd_mux = {30'd0, r_ctrl};
            LP_ADDR_PERIOD: w_rd_mux = {16'd0, r_period};
            LP_ADDR_STATUS: w_rd_mux = {16'd0, r_pwm_ctr, 7'd0, (r_state == ST_BLINK_OFF)};
            default:        w_rd_mux = '0;
        endcase
    end

    // Prescaler and PWM step counter, held at zero while disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc   <= '0;
            r_pwm_ctr <= '0;
        end else if (!w_en_next) begin
            r_presc   <= '0;
            r_pwm_ctr <= '0;
        end else if (r_ctrl[0]) begin
            if (w_tick) begin
                r_presc   <= '0;
                r_pwm_ctr <= r_pwm_ctr + 8'd1;
            end else begin
                r_presc   <= r_presc + 16'd1;
            end
        end
    end

    // Blink FSM state and frame counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_SOLID;
            r_frame_ctr <= '0;
        end else begin
            r_state     <= w_state_next;
            r_frame_ctr <= w_frame_next;
        end
    end

    // Blink FSM next state: toggle phase after max(PERIOD,1) frame ends
    always_comb begin
        w_state_next = r_state;
        w_frame_next = r_frame_ctr;
        case (r_state)
            ST_SOLID: begin
                w_frame_next = '0;
                if (w_ctrl_next == 2'b11) w_state_next = ST_BLINK_ON;
            end
            ST_BLINK_ON, ST_BLINK_OFF: begin
                if (w_frame_end) begin
                    if (r_frame_ctr == w_period_max) begin
                        w_frame_next = '0;
                        w_state_next = (r_state == ST_BLINK_ON) ? ST_BLINK_OFF : ST_BLINK_ON;
                    end else begin
                        w_frame_next = r_frame_ctr + 16'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_SOLID;
                w_frame_next = '0;
            end
        endcase
        if (w_wr_period) w_frame_next = '0;
        if (w_ctrl_next != 2'b11) begin
            w_state_next = ST_SOLID;
            w_frame_next = '0;
        end
    end

    // One channel per colour: R in DUTY[23:16], G in [15:8], B in [7:0]
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        logic [7:0] r_active;
        logic       r_led;

        // Active duty reloads only at frame end or when enable rises
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_active <= '0;
                r_led    <= 1'b0;
            end else begin
                if (w_load_active) r_active <= r_duty[8*(2-gi) +: 8];
                r_led <= r_ctrl[0] && w_en_next && w_phase_on && (r_pwm_ctr < r_active);
            end
        end
    end

    assign led_r     = g_ch[0].r_led;
    assign led_g     = g_ch[1].r_led;
    assign led_b     = g_ch[2].r_led;
    assign read_data = r_read_data;
    assign ready     = r_ready;

endmodule

// File: tb/tb_led_pwm.sv
// Directed self-checking bench for led_pwm (PRESCALE=1 main instance,
// PRESCALE=4 side instance sharing the same register bus).
module tb_led_pwm;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic        led_r, led_g, led_b;
    logic [31:0] read_data4;
    logic        ready4;
    logic        led_r4, led_g4, led_b4;

    int checks = 0;
    int fails  = 0;
    int hi_r = 0, hi_g = 0, hi_b = 0, hi_r4 = 0;

    led_pwm #(.PRESCALE(1)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .led_r(led_r), .led_g(led_g), .led_b(led_b)
    );

    led_pwm #(.PRESCALE(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(read_data4), .ready(ready4),
        .led_r(led_r4), .led_g(led_g4), .led_b(led_b4)
    );

    always #5 clk = ~clk;

    // Cumulative high-cycle counters, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        if (led_r)  hi_r++;
        if (led_g)  hi_g++;
        if (led_b)  hi_b++;
        if (led_r4) hi_r4++;
    end

    // Bus helpers: called at a negedge, consume exactly one clock cycle
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        cs = 1'b1; we = 1'b1; address = a; write_data = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
        $display("write addr=0x%02h data=0x%08h", a, d);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic rdy);
        cs = 1'b1; we = 1'b0; address = a;
        @(negedge clk);
        cs = 1'b0;
        d = read_data; rdy = ready;
        $display("read  addr=0x%02h data=0x%08h ready=%0b", a, d, rdy);
    endtask

    task automatic test_reset();
        logic [31:0] d; logic rdy;
        if ({led_r, led_g, led_b} !== 3'b000) begin
            $display("FAIL reset_leds got=%b want=000", {led_r, led_g, led_b}); fails++;
        end
        checks++;
        if (ready !== 1'b0 || read_data !== 32'd0) begin
            $display("FAIL reset_bus got ready=%b data=0x%08h want 0/0", ready, read_data); fails++;
        end
        checks++;
        @(negedge clk); reset_n = 1'b1; @(negedge clk);
        bus_read(8'h00, d, rdy);
        if (d !== 32'd0) begin $display("FAIL reset_duty got=0x%08h want=0", d); fails++; end
        checks++;
        bus_read(8'h01, d, rdy);
        if (d !== 32'd0) begin $display("FAIL reset_ctrl got=0x%08h want=0", d); fails++; end
        checks++;
        bus_read(8'h02, d, rdy);
        if (d !== 32'd64) begin $display("FAIL reset_period got=0x%08h want=0x40", d); fails++; end
        checks++;
        bus_read(8'h03, d, rdy);
        if (d !== 32'd0) begin $display("FAIL reset_status got=0x%08h want=0", d); fails++; end
        checks++;
    endtask

    task automatic test_register_access();
        logic [31:0] d; logic rdy;
        bus_write(8'h00, 32'h00FF8001);
        bus_read(8'h00, d, rdy);
        if (d !== 32'h00FF8001 || rdy !== 1'b1) begin
            $display("FAIL reg_duty got=0x%08h rdy=%b want=0x00ff8001 rdy=1", d, rdy); fails++;
        end
        checks++;
        @(negedge clk);
        if (ready !== 1'b0 || read_data !== 32'd0) begin
            $display("FAIL reg_ready_pulse got ready=%b data=0x%08h want 0/0", ready, read_data); fails++;
        end
        checks++;
        bus_read(8'h07, d, rdy);
        if (d !== 32'd0 || rdy !== 1'b1) begin
            $display("FAIL reg_unmapped got=0x%08h rdy=%b want=0 rdy=1", d, rdy); fails++;
        end
        checks++;
        bus_write(8'h00, 32'hFFFFFFFF);
        bus_read(8'h00, d, rdy);
        if (d !== 32'h00FFFFFF) begin $display("FAIL reg_duty_mask got=0x%08h want=0x00ffffff", d); fails++; end
        checks++;
        bus_write(8'h01, 32'hFFFFFFFC);
        bus_read(8'h01, d, rdy);
        if (d !== 32'd0) begin $display("FAIL reg_ctrl_mask got=0x%08h want=0", d); fails++; end
        checks++;
        bus_write(8'h02, 32'hABCD1234);
        bus_read(8'h02, d, rdy);
        if (d !== 32'h00001234) begin $display("FAIL reg_period_mask got=0x%08h want=0x1234", d); fails++; end
        checks++;
        bus_write(8'h03, 32'hFFFFFFFF);
        bus_write(8'h10, 32'hFFFFFFFF);
        bus_read(8'h03, d, rdy);
        if (d !== 32'd0) begin $display("FAIL reg_status_ro got=0x%08h want=0", d); fails++; end
        checks++;
        bus_read(8'h10, d, rdy);
        if (d !== 32'd0) begin $display("FAIL reg_unmapped_wr got=0x%08h want=0", d); fails++; end
        checks++;
    endtask

    task automatic test_duty_cycle();
        int s;
        bus_write(8'h00, 32'h00400000);
        bus_write(8'h01, 32'd1);
        s = hi_r;
        repeat (256) @(negedge clk);
        if (hi_r - s !== 64) begin $display("FAIL duty_40 got=%0d want=64", hi_r - s); fails++; end
        checks++;
        bus_write(8'h00, 32'h00FF0000);
        repeat (300) @(negedge clk);
        s = hi_r;
        repeat (256) @(negedge clk);
        if (hi_r - s !== 255) begin $display("FAIL duty_ff got=%0d want=255", hi_r - s); fails++; end
        checks++;
        if (hi_g !== 0 || hi_b !== 0) begin
            $display("FAIL duty_gb_zero got g=%0d b=%0d want 0/0", hi_g, hi_b); fails++;
        end
        checks++;
        bus_write(8'h01, 32'd0);
    endtask

    task automatic test_glitch_free();
        int s0, s1, s2;
        bus_write(8'h00, 32'h00400000);
        bus_write(8'h01, 32'd1);
        s0 = hi_r;
        repeat (99) @(negedge clk);
        bus_write(8'h00, 32'h00800000);
        repeat (156) @(negedge clk);
        s1 = hi_r;
        if (s1 - s0 !== 64) begin $display("FAIL glitch_cur_frame got=%0d want=64", s1 - s0); fails++; end
        checks++;
        repeat (256) @(negedge clk);
        s2 = hi_r;
        if (s2 - s1 !== 128) begin $display("FAIL glitch_next_frame got=%0d want=128", s2 - s1); fails++; end
        checks++;
        bus_write(8'h01, 32'd0);
    endtask

    task automatic test_blink();
        int s0, s1, s2, s3;
        logic [31:0] d; logic rdy;
        bus_write(8'h02, 32'd2);
        bus_write(8'h00, 32'h00FF0000);
        bus_write(8'h01, 32'd3);
        s0 = hi_r;
        repeat (256) @(negedge clk);
        bus_read(8'h03, d, rdy);
        if (d !== 32'd0) begin $display("FAIL blink_status_on got=0x%08h want=0", d); fails++; end
        checks++;
        repeat (255) @(negedge clk);
        s1 = hi_r;
        if (s1 - s0 !== 510) begin $display("FAIL blink_on_frames got=%0d want=510", s1 - s0); fails++; end
        checks++;
        bus_read(8'h03, d, rdy);
        if (d !== 32'd1) begin $display("FAIL blink_status_off got=0x%08h want=1", d); fails++; end
        checks++;
        repeat (511) @(negedge clk);
        s2 = hi_r;
        if (s2 - s1 !== 0) begin $display("FAIL blink_off_frames got=%0d want=0", s2 - s1); fails++; end
        checks++;
        bus_read(8'h03, d, rdy);
        if (d !== 32'd0) begin $display("FAIL blink_status_on2 got=0x%08h want=0", d); fails++; end
        checks++;
        repeat (511) @(negedge clk);
        s3 = hi_r;
        if (s3 - s2 !== 510) begin $display("FAIL blink_on_again got=%0d want=510", s3 - s2); fails++; end
        checks++;
        // PERIOD=0 behaves as 1: toggle every frame
        bus_write(8'h01, 32'd0);
        bus_write(8'h02, 32'd0);
        bus_write(8'h01, 32'd3);
        s0 = hi_r;
        repeat (256) @(negedge clk);
        s1 = hi_r;
        if (s1 - s0 !== 255) begin $display("FAIL blink_p0_on got=%0d want=255", s1 - s0); fails++; end
        checks++;
        bus_read(8'h03, d, rdy);
        if (d !== 32'd1) begin $display("FAIL blink_p0_status got=0x%08h want=1", d); fails++; end
        checks++;
        repeat (255) @(negedge clk);
        s2 = hi_r;
        if (s2 - s1 !== 0) begin $display("FAIL blink_p0_off got=%0d want=0", s2 - s1); fails++; end
        checks++;
        repeat (256) @(negedge clk);
        s3 = hi_r;
        if (s3 - s2 !== 255) begin $display("FAIL blink_p0_on2 got=%0d want=255", s3 - s2); fails++; end
        checks++;
        bus_write(8'h01, 32'd0);
    endtask

    task automatic test_disable();
        int s;
        logic [31:0] d; logic rdy;
        bus_write(8'h00, 32'h00FF0000);
        bus_write(8'h01, 32'd1);
        repeat (100) @(negedge clk);
        if (led_r !== 1'b1) begin $display("FAIL dis_running got=%b want=1", led_r); fails++; end
        checks++;
        bus_write(8'h01, 32'd0);
        if (led_r !== 1'b0) begin $display("FAIL dis_led_off got=%b want=0", led_r); fails++; end
        checks++;
        bus_read(8'h03, d, rdy);
        if (d !== 32'd0) begin $display("FAIL dis_status got=0x%08h want=0", d); fails++; end
        checks++;
        s = hi_r;
        repeat (300) @(negedge clk);
        if (hi_r - s !== 0) begin $display("FAIL dis_stays_low got=%0d want=0", hi_r - s); fails++; end
        checks++;
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d; logic rdy;
        bus_write(8'h02, 32'd5);
        bus_write(8'h01, 32'd1);
        repeat (50) @(negedge clk);
        if (led_r !== 1'b1) begin $display("FAIL rst_pre_led got=%b want=1", led_r); fails++; end
        checks++;
        #1 reset_n = 1'b0;
        #1;
        if ({led_r, led_g, led_b} !== 3'b000) begin
            $display("FAIL rst_async_leds got=%b want=000", {led_r, led_g, led_b}); fails++;
        end
        checks++;
        @(negedge clk); reset_n = 1'b1; @(negedge clk);
        bus_read(8'h00, d, rdy);
        if (d !== 32'd0) begin $display("FAIL rst_mid_duty got=0x%08h want=0", d); fails++; end
        checks++;
        bus_read(8'h01, d, rdy);
        if (d !== 32'd0) begin $display("FAIL rst_mid_ctrl got=0x%08h want=0", d); fails++; end
        checks++;
        bus_read(8'h02, d, rdy);
        if (d !== 32'd64) begin $display("FAIL rst_mid_period got=0x%08h want=0x40", d); fails++; end
        checks++;
        // Access interrupted by reset must not produce a ready pulse
        cs = 1'b1; we = 1'b0; address = 8'h02;
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        if (ready !== 1'b0 || read_data !== 32'd0) begin
            $display("FAIL rst_access got ready=%b data=0x%08h want 0/0", ready, read_data); fails++;
        end
        checks++;
        @(negedge clk); cs = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        if (ready !== 1'b0) begin $display("FAIL rst_access_after got=%b want=0", ready); fails++; end
        checks++;
    endtask

    task automatic test_prescale();
        int s, s4;
        bus_write(8'h00, 32'h00010000);
        bus_write(8'h01, 32'd1);
        repeat (1100) @(negedge clk);
        s = hi_r; s4 = hi_r4;
        repeat (1024) @(negedge clk);
        if (hi_r4 - s4 !== 4) begin $display("FAIL presc4_duty1 got=%0d want=4", hi_r4 - s4); fails++; end
        checks++;
        if (hi_r - s !== 4) begin $display("FAIL presc1_duty1 got=%0d want=4", hi_r - s); fails++; end
        checks++;
        bus_write(8'h01, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_register_access();
        test_duty_cycle();
        test_glitch_free();
        test_blink();
        test_disable();
        test_reset_mid_frame();
        test_prescale();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/led_pwm.md
LED_PWM -- requirements
Module: led_pwm

Interface
REQ-001 SHALL have parameter PRESCALE, default 16, meaning clk cycles per PWM step (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cs  input  1  register access strobe, one cycle per access.
REQ-005 SHALL have port we  input  1  write enable, qualified by cs.
REQ-006 SHALL have port address  input  8  register index.
REQ-007 SHALL have port write_data  input  32  write payload.
REQ-008 SHALL have port read_data  output  32  read payload, registered.
REQ-009 SHALL have port ready  output  1  access-complete strobe.
REQ-010 SHALL have ports led_r, led_g, led_b  output  1 each  PWM drive toward RGB0PWM/RGB1PWM/RGB2PWM of the RGB driver.

Function
REQ-011 SHALL decode registers:
- 0x00 DUTY rw: [23:16] R, [15:8] G, [7:0] B.
- 0x01 CTRL rw: [0] enable, [1] blink.
- 0x02 PERIOD rw: [15:0] blink half-period in PWM frames.
- 0x03 STATUS ro: [0] blink phase, [15:8] current pwm_ctr.
REQ-012 SHALL, for any cs access, assert ready for exactly one cycle, the cycle after cs; read_data valid in that cycle, 0 otherwise.
REQ-013 SHALL apply writes on the clock edge where cs && we; unused bits and unmapped addresses SHALL read 0 and ignore writes.
REQ-014 SHALL run a prescaler 0..PRESCALE-1 while enable=1; tick = prescaler at PRESCALE-1.
REQ-015 SHALL increment 8-bit pwm_ctr on each tick, wrapping 255->0; frame_end = tick && pwm_ctr==255.
REQ-016 SHALL hold prescaler, pwm_ctr, frame counter and phase at 0 while enable=0; all LED outputs 0.
REQ-017 SHALL keep active duty registers; these load from DUTY only at frame_end or on the cycle enable rises 0->1.
REQ-018 SHALL load the pre-write DUTY value when a DUTY write coincides with frame_end; the new value applies at the next frame_end.
REQ-019 SHALL drive each output registered as enable && phase_on && (pwm_ctr < active_duty); duty 0 => always low, duty 255 => high 255 of 256 steps.
REQ-020 SHALL implement blink FSM with states SOLID, BLINK_ON, BLINK_OFF; phase_on=1 in SOLID and BLINK_ON, 0 in BLINK_OFF.
REQ-021 SHALL transition SOLID->BLINK_ON when blink=1 and enable=1; any state->SOLID when blink=0 or enable=0.
REQ-022 SHALL count frame_end events in a 16-bit frame counter in BLINK_ON/BLINK_OFF; at count==max(PERIOD,1)-1 with frame_end, toggle ON<->OFF and clear counter.
REQ-023 SHALL treat PERIOD=0 as 1 (toggle every frame).
REQ-024 SHALL clear the frame counter on any PERIOD write; new period applies immediately.
REQ-025 SHALL report STATUS[0]=1 only in BLINK_OFF.

Reset
REQ-026 SHALL, on reset_n low, immediately set led_r/g/b=0, ready=0, read_data=0, DUTY=0, active duty=0, CTRL=0, PERIOD=16'd64, all counters 0, FSM=SOLID.
REQ-027 SHALL recover cleanly when reset asserts mid-frame or mid-access; no ready pulse for an access interrupted by reset.

Verification (PRESCALE=1 unless stated)
REQ-028 SHALL verify register access: write DUTY=0x00FF8001, read 0x00 -> read_data=0x00FF8001, ready high one cycle after cs; read 0x07 -> 0.
REQ-029 SHALL verify duty cycle: DUTY=0x00400000, enable=1 -> led_r high 64 of 256 cycles per frame, led_g/led_b constant 0; duty 0xFF -> high 255 of 256.
REQ-030 SHALL verify glitch-free update: change R duty 0x40->0x80 mid-frame -> current frame stays 64 high, next frame 128 high.
REQ-031 SHALL verify blink: PERIOD=2, CTRL=3, DUTY R=0xFF -> output active 2 frames (512 cycles), silent 2 frames, STATUS[0] tracks; PERIOD=0 -> toggles every frame.
REQ-032 SHALL verify disable/reset: clear enable mid-frame -> outputs 0 next cycle, STATUS[15:8]=0; assert reset_n low mid-frame -> outputs 0 without clock edge, registers at REQ-026 values.
REQ-033 SHALL verify prescale: PRESCALE=4, R duty=0x01 -> led_r high 4 cycles per 1024-cycle frame.
